// File: rtl/relu_sequencer.sv
// relu_sequencer: counts the pixels of one image, snapshots the layer-1
// accumulator sums plus bias through ReLU and requantisation, then streams
// one activation per node to layer 2 over a valid/ready handshake. The
// accumulator is cleared between images.
module relu_sequencer #(
  parameter int NODES      = 16,
  parameter int IN_W       = 24,
  parameter int OUT_W      = 8,
  parameter int NUM_INPUTS = 784,
  parameter int SHIFT      = 8,
  localparam int IDX_W     = (NODES > 1) ? $clog2(NODES) : 1
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  pixValid,
  output logic                  inReady,
  input  logic [NODES*IN_W-1:0] sumIn,
  input  logic [NODES*IN_W-1:0] biasIn,
  output logic                  accClr,
  output logic [OUT_W-1:0]      actOut,
  output logic [IDX_W-1:0]      actIdx,
  output logic                  actValid,
  output logic                  actLast,
  input  logic                  actReady
);

  localparam int CNT_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;

  // Ceiling of the requantised value, held in a width that can never
  // truncate the shifted sum regardless of how IN_W and OUT_W compare.
  localparam logic [IN_W+OUT_W:0] SAT_MAX = {{(IN_W+1){1'b0}}, {OUT_W{1'b1}}};

  typedef enum logic [1:0] {
    S_CLEAR  = 2'd0,
    S_ACCUM  = 2'd1,
    S_SETTLE = 2'd2,
    S_EMIT   = 2'd3
  } state_t;

  state_t             state;
  state_t             nxt_state;
  logic [CNT_W-1:0]   pix_cnt;
  logic [IDX_W-1:0]   node_idx;
  logic [OUT_W-1:0]   act_buf [NODES];
  logic               pix_last;
  logic               node_last;

  // Bias add in IN_W+1 bits so the sum cannot wrap, ReLU, arithmetic shift,
  // then clamp to the unsigned OUT_W range.
  function automatic logic [OUT_W-1:0] relu_sat(input logic signed [IN_W-1:0] s,
                                                 input logic signed [IN_W-1:0] b);
    logic signed [IN_W:0]   r;
    logic signed [IN_W:0]   q;
    logic [IN_W+OUT_W:0]    qw;
    r  = (IN_W+1)'(s) + (IN_W+1)'(b);
    q  = r >>> SHIFT;
    qw = {{OUT_W{1'b0}}, q};
    if (r[IN_W])
      return '0;
    else if (qw > SAT_MAX)
      return '1;
    else
      return qw[OUT_W-1:0];
  endfunction

  assign pix_last  = (pix_cnt == CNT_W'(NUM_INPUTS - 1));
  assign node_last = (node_idx == IDX_W'(NODES - 1));

  // State register.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) state <= S_CLEAR;
    else     state <= nxt_state;
  end

  // Next-state logic: CLEAR -> ACCUM -> SETTLE -> EMIT -> CLEAR.
  always_comb begin
    nxt_state = state;
    case (state)
      S_CLEAR:  nxt_state = S_ACCUM;
      S_ACCUM:  if (pixValid && pix_last) nxt_state = S_SETTLE;
      S_SETTLE: nxt_state = S_EMIT;
      S_EMIT:   if (actReady && node_last) nxt_state = S_CLEAR;
      default:  nxt_state = S_CLEAR;
    endcase
  end

  // Output decode; every output is a function of flops only, so nothing
  // moves between clock edges.
  always_comb begin
    inReady  = 1'b0;
    accClr   = 1'b0;
    actValid = 1'b0;
    actLast  = 1'b0;
    actOut   = '0;
    actIdx   = '0;
    case (state)
      S_CLEAR: accClr = 1'b1;
      S_ACCUM: inReady = 1'b1;
      S_EMIT: begin
        actValid = 1'b1;
        actOut   = act_buf[node_idx];
        actIdx   = node_idx;
        actLast  = node_last;
      end
      default: ;
    endcase
  end

  // Pixel counter: only accepts in ACCUM count; restarts each image.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      pix_cnt <= '0;
    end else if (state == S_CLEAR) begin
      pix_cnt <= '0;
    end else if (state == S_ACCUM && pixValid) begin
      pix_cnt <= pix_last ? '0 : pix_cnt + 1'b1;
    end
  end

  // Node pointer: advances on each accepted activation, holds while stalled.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      node_idx <= '0;
    end else if (state == S_CLEAR) begin
      node_idx <= '0;
    end else if (state == S_EMIT && actReady) begin
      node_idx <= node_last ? '0 : node_idx + 1'b1;
    end
  end

  // ---- snapshot stage: accumulator settled during SETTLE, capture all lanes ----
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      for (int m = 0; m < NODES; m++) act_buf[m] <= '0;
    end else if (state == S_SETTLE) begin
      for (int m = 0; m < NODES; m++)
        act_buf[m] <= relu_sat(sumIn[m*IN_W +: IN_W], biasIn[m*IN_W +: IN_W]);
    end
  end

endmodule

// File: tb/tb_relu_sequencer.sv
// Testbench for relu_sequencer: a small accumulator model feeds the sums,
// per-lane vectors carry hand-computed activations, and hand-written
// sequences cover reset during EMIT, stalls and back-to-back images.
module tb_relu_sequencer;

  localparam int NODES      = 4;
  localparam int IN_W       = 24;
  localparam int OUT_W      = 8;
  localparam int NUM_INPUTS = 4;
  localparam int SHIFT      = 8;
  localparam int IDX_W      = 2;

  logic                  clk = 1'b0;
  logic                  clr = 1'b0;
  logic                  pixValid;
  logic                  inReady;
  logic [NODES*IN_W-1:0] sumIn;
  logic [NODES*IN_W-1:0] biasIn;
  logic                  accClr;
  logic [OUT_W-1:0]      actOut;
  logic [IDX_W-1:0]      actIdx;
  logic                  actValid;
  logic                  actLast;
  logic                  actReady;

  always #5 clk = ~clk;

  relu_sequencer #(
    .NODES(NODES), .IN_W(IN_W), .OUT_W(OUT_W),
    .NUM_INPUTS(NUM_INPUTS), .SHIFT(SHIFT)
  ) dut (
    .clk(clk), .clr(clr), .pixValid(pixValid), .inReady(inReady),
    .sumIn(sumIn), .biasIn(biasIn), .accClr(accClr),
    .actOut(actOut), .actIdx(actIdx), .actValid(actValid),
    .actLast(actLast), .actReady(actReady)
  );

  typedef struct {
    logic signed [IN_W-1:0] sum;
    logic signed [IN_W-1:0] bias;
    logic [OUT_W-1:0]       exp;
  } vec_t;

  vec_t                   vt  [8];
  logic signed [IN_W-1:0] tgt [NODES];
  logic signed [IN_W-1:0] acc [NODES];
  int                     acc_k;
  int                     n_cmp = 0;
  int                     n_bad = 0;

  // Upstream accumulator model: first accepted pixel of an image carries the
  // target sum, later pixels add zero; accClr empties it.
  always_ff @(posedge clk) begin
    if (accClr) begin
      for (int m = 0; m < NODES; m++) acc[m] <= '0;
      acc_k <= 0;
    end else if (pixValid && inReady) begin
      for (int m = 0; m < NODES; m++) acc[m] <= acc[m] + ((acc_k == 0) ? tgt[m] : '0);
      acc_k <= acc_k + 1;
    end
  end

  always_comb begin
    sumIn = '0;
    for (int m = 0; m < NODES; m++) sumIn[m*IN_W +: IN_W] = acc[m];
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  // Runs one image from the current negedge until all NODES activations are
  // transferred; returns cycles used and the number of accClr cycles seen.
  task automatic run_image(input int base, input bit gapped, input bit stall,
                           input bit hold_pv, output int period, output int clr_seen);
    bit               gpat [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    bit               rpat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int               pv_i = 0, ri = 0, node = 0, cyc = 0, accepts = 0;
    int               final_acc = -1, first_vld = -1;
    bit               stalled = 1'b0;
    logic [OUT_W-1:0] prev_out = '0;
    for (int m = 0; m < NODES; m++) begin
      tgt[m] = vt[base+m].sum;
      biasIn[m*IN_W +: IN_W] = vt[base+m].bias;
    end
    clr_seen = 0;
    while (node < NODES && cyc < 80) begin
      if (accClr) clr_seen++;
      if (inReady) begin
        pixValid = gapped ? ((pv_i < 5) ? gpat[pv_i] : 1'b1) : 1'b1;
        pv_i++;
        if (pixValid) begin
          accepts++;
          if (accepts == NUM_INPUTS) final_acc = cyc;
        end
      end else begin
        pixValid = hold_pv;
      end
      if (actValid) begin
        if (first_vld < 0) first_vld = cyc;
        chk("emit_inReady", inReady, 0);
        chk("emit_idx", actIdx, node);
        chk("emit_out", actOut, vt[base+node].exp);
        chk("emit_last", actLast, (node == NODES-1));
        if (stalled) chk("stall_hold", actOut, prev_out);
        prev_out = actOut;
        actReady = stall ? rpat[ri % 4] : 1'b1;
        ri++;
        stalled = !actReady;
        if (actReady) node++;
      end else begin
        actReady = stall ? 1'b0 : 1'b1;
      end
      @(negedge clk);
      cyc++;
    end
    pixValid = 1'b0;
    chk("all_nodes_sent", node, NODES);
    chk("accepts", accepts, NUM_INPUTS);
    chk("latency", first_vld - final_acc, 2);
    chk("end_accClr", accClr, 1);
    chk("end_actValid", actValid, 0);
    period = cyc;
  endtask

  initial begin
    int per, cs;
    vt[0] = '{sum: -24'sd500,       bias: 24'sd100,      exp: 8'd0};
    vt[1] = '{sum: 24'sd1000,       bias: 24'sd24,       exp: 8'd4};
    vt[2] = '{sum: 24'sh7FFFFF,     bias: 24'sd0,        exp: 8'd255};
    vt[3] = '{sum: 24'sd65279,      bias: 24'sd0,        exp: 8'd254};
    vt[4] = '{sum: -24'sd256,       bias: 24'sd256,      exp: 8'd0};
    vt[5] = '{sum: 24'sd256,        bias: 24'sd0,        exp: 8'd1};
    vt[6] = '{sum: 24'sh7FFFFF,     bias: 24'sh7FFFFF,   exp: 8'd255};
    vt[7] = '{sum: 24'sh800000,     bias: 24'sh800000,   exp: 8'd0};
    pixValid = 1'b0;
    actReady = 1'b0;
    biasIn   = '0;
    for (int m = 0; m < NODES; m++) tgt[m] = '0;

    // Reset values
    #1 clr = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_accClr", accClr, 1);
    chk("rst_actValid", actValid, 0);
    chk("rst_actLast", actLast, 0);
    chk("rst_actOut", actOut, 0);
    chk("rst_actIdx", actIdx, 0);
    chk("rst_inReady", inReady, 0);
    clr = 1'b0;
    #1 chk("rel_accClr", accClr, 1);
    @(negedge clk);
    chk("rel_accClr_done", accClr, 0);
    chk("rel_inReady", inReady, 1);

    // Image A: gapped pixels and stalled emission
    run_image(0, 1'b1, 1'b1, 1'b0, per, cs);

    // Image B back-to-back, pixValid held high outside ACCUM
    run_image(4, 1'b0, 1'b0, 1'b1, per, cs);
    chk("period", per, NUM_INPUTS + NODES + 2);
    chk("accClr_pulses", cs, 1);

    // Reset in the middle of EMIT
    for (int m = 0; m < NODES; m++) begin
      tgt[m] = vt[m].sum;
      biasIn[m*IN_W +: IN_W] = vt[m].bias;
    end
    actReady = 1'b0;
    for (int c = 0; c < 20 && !actValid; c++) begin
      pixValid = inReady;
      @(negedge clk);
    end
    pixValid = 1'b0;
    chk("pre_rst_actValid", actValid, 1);
    @(negedge clk);
    clr = 1'b1;
    #1;
    chk("mid_rst_actValid", actValid, 0);
    chk("mid_rst_accClr", accClr, 1);
    chk("mid_rst_inReady", inReady, 0);
    chk("mid_rst_actOut", actOut, 0);
    @(negedge clk);
    clr = 1'b0;
    #1 chk("mid_rel_accClr", accClr, 1);
    @(negedge clk);
    chk("mid_rel_accClr_done", accClr, 0);
    chk("mid_rel_inReady", inReady, 1);

    // Recovery image after the abort
    run_image(4, 1'b0, 1'b0, 1'b0, per, cs);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
